packet_scheduler: RTL and testbench



---
 rtl/packet_scheduler.sv | 150 +++++++++++++++
 tb/tb_packet_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/packet_scheduler.sv
// Data-island packet scheduler: audio FIFO, per-field InfoFrames, ACR, Null; one packet per slot.
// Optional ACR scheduling is enabled by defining ACR_PACKET_EN.
module packet_scheduler #(
  parameter int          AUDIO_FIFO_DEPTH = 8,
  parameter logic [7:0]  VIC              = 8'd16,
  parameter logic [19:0] ACR_N            = 20'd6144,
  parameter logic [19:0] ACR_CTS          = 20'd74250
) (
  input  logic         clk_pixel,
  input  logic         reset_n,
  input  logic         packet_enable,
  input  logic         video_field_end,
  input  logic         audio_valid,
  output logic         audio_ready,
  input  logic [23:0]  audio_left,
  input  logic [23:0]  audio_right,
  output logic [23:0]  header,
  output logic [223:0] sub,
  output logic [2:0]   packet_type
);

  localparam int AW = $clog2(AUDIO_FIFO_DEPTH);
  localparam logic [AW:0] FOUR = (AW+1)'(4);

  typedef enum logic [2:0] {
    PKT_NULL  = 3'd0,
    PKT_AUDIO = 3'd1,
    PKT_ACR   = 3'd2,
    PKT_AVI   = 3'd3,
    PKT_AIF   = 3'd4
  } pkt_t;

  localparam logic [55:0] ACR_SUB = {ACR_N[7:0], ACR_N[15:8], 4'b0, ACR_N[19:16],
                                     ACR_CTS[7:0], ACR_CTS[15:8], 4'b0, ACR_CTS[19:16], 8'h00};
  localparam logic [7:0] AVI_CSUM = 8'(8'h00 - (8'h82 + 8'h02 + 8'h0D + 8'h28 + VIC));
  localparam logic [7:0] AIF_CSUM = 8'(8'h00 - (8'h84 + 8'h01 + 8'h0A + 8'h01));

  logic [23:0]   fifo_l [AUDIO_FIFO_DEPTH];
  logic [23:0]   fifo_r [AUDIO_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, idx;
  logic [AW:0]   count, count_next;
  logic [7:0]    frame_cnt, frame_next, fc;
  logic          acr_pend, avi_pend, aif_pend;
  logic          push;
  logic [2:0]    pop, pop_eff;
  logic [23:0]   l_smp, r_smp;
  logic [23:0]   hdr_next;
  logic [223:0]  sub_next;
  pkt_t          sel;

  assign audio_ready = (count != (AW+1)'(AUDIO_FIFO_DEPTH));
  assign push        = audio_valid && audio_ready;
  assign pop_eff     = packet_enable ? pop : 3'd0;
  assign count_next  = count + (AW+1)'(push) - (AW+1)'(pop_eff);

  always_comb begin
    sel = PKT_NULL;
    if (count != '0)   sel = PKT_AUDIO;
    else if (acr_pend) sel = PKT_ACR;
    else if (avi_pend) sel = PKT_AVI;
    else if (aif_pend) sel = PKT_AIF;
  end

  // Build the candidate packet; it is only committed on packet_enable.
  always_comb begin
    hdr_next   = '0;
    sub_next   = '0;
    pop        = 3'd0;
    frame_next = frame_cnt;
    fc         = frame_cnt;
    idx        = rd_ptr;
    l_smp      = '0;
    r_smp      = '0;
    case (sel)
      PKT_AUDIO: begin
        pop = (count > FOUR) ? 3'd4 : 3'(count);
        hdr_next[7:0] = 8'h02;
        for (int i = 0; i < 4; i++) begin
          if (3'(i) < pop) begin
            idx   = rd_ptr + AW'(i);
            l_smp = fifo_l[idx];
            r_smp = fifo_r[idx];
            sub_next[56*i +: 56] = {^r_smp, 3'b000, ^l_smp, 3'b000, r_smp, l_smp};
            hdr_next[8+i] = 1'b1;
            if (fc == 8'd0) hdr_next[20+i] = 1'b1;
            fc = (fc == 8'd191) ? 8'd0 : fc + 8'd1;
          end
        end
        frame_next = fc;
      end
      PKT_ACR: begin
        hdr_next = 24'h000001;
        sub_next = {4{ACR_SUB}};
      end
      PKT_AVI: begin
        hdr_next       = 24'h0D0282;
        sub_next[39:0] = {VIC, 8'h00, 8'h28, 8'h00, AVI_CSUM};
      end
      PKT_AIF: begin
        hdr_next       = 24'h0A0184;
        sub_next[15:0] = {8'h01, AIF_CSUM};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (push) begin
      fifo_l[wr_ptr] <= audio_left;
      fifo_r[wr_ptr] <= audio_right;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      header      <= '0;
      sub         <= '0;
      packet_type <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      frame_cnt   <= '0;
      avi_pend    <= 1'b0;
      aif_pend    <= 1'b0;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (packet_enable) begin
        header      <= hdr_next;
        sub         <= sub_next;
        packet_type <= sel;
        rd_ptr      <= rd_ptr + AW'(pop);
        frame_cnt   <= frame_next;
      end
      // A field end on the selecting cycle re-arms the flag.
      avi_pend <= video_field_end | (avi_pend & ~(packet_enable && sel == PKT_AVI));
      aif_pend <= video_field_end | (aif_pend & ~(packet_enable && sel == PKT_AIF));
    end
  end

`ifdef ACR_PACKET_EN
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) acr_pend <= 1'b0;
    else          acr_pend <= video_field_end | (acr_pend & ~(packet_enable && sel == PKT_ACR));
  end
`else
  assign acr_pend = 1'b0;
`endif

endmodule

// File: tb/tb_packet_scheduler.sv
// Randomized self-checking bench for packet_scheduler against a queue-based packet model.
module tb_packet_scheduler;

`ifdef ACR_PACKET_EN
  localparam bit ACR_ON = 1'b1;
`else
  localparam bit ACR_ON = 1'b0;
`endif
  localparam int DEPTH = 8;
  localparam int CTS   = 74250;
  localparam int NVAL  = 6144;

  logic         clk_pixel = 1'b0;
  logic         reset_n;
  logic         packet_enable, video_field_end, audio_valid, audio_ready;
  logic [23:0]  audio_left, audio_right, header;
  logic [223:0] sub;
  logic [2:0]   packet_type;

  packet_scheduler dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_enable(packet_enable),
    .video_field_end(video_field_end), .audio_valid(audio_valid), .audio_ready(audio_ready),
    .audio_left(audio_left), .audio_right(audio_right), .header(header), .sub(sub),
    .packet_type(packet_type)
  );

  always #5 clk_pixel = ~clk_pixel;

  int           checks = 0;
  int           errors = 0;
  logic [47:0]  fifo_q[$];
  bit           m_acr, m_avi, m_aif;
  int           iec, pairs_done;
  logic [23:0]  exp_header;
  logic [223:0] exp_sub;
  logic [2:0]   exp_type;
  bit           saw_avi;

  task automatic checkOutput(input string tag, input logic [223:0] obs, input logic [223:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_type"}, 224'(packet_type), 224'(exp_type));
    checkOutput({tag, "_hdr"}, 224'(header), 224'(exp_header));
    checkOutput({tag, "_sub"}, sub, exp_sub);
    checkOutput({tag, "_ready"}, 224'(audio_ready), 224'(fifo_q.size() < DEPTH));
  endtask

  task automatic model_reset();
    fifo_q.delete();
    m_acr = 0; m_avi = 0; m_aif = 0;
    iec = 0;
    exp_header = '0; exp_sub = '0; exp_type = '0;
  endtask

  task automatic model_infoframe(input logic [7:0] h0, h1, h2, pb1, pb2, pb4);
    logic [7:0] pb[28];
    int sum;
    foreach (pb[k]) pb[k] = 8'h00;
    pb[1] = pb1; pb[2] = pb2; pb[4] = pb4;
    sum = int'(h0) + int'(h1) + int'(h2);
    for (int k = 1; k < 28; k++) sum += int'(pb[k]);
    pb[0] = 8'((256 - (sum % 256)) % 256);
    exp_header = {h2, h1, h0};
    for (int k = 0; k < 28; k++) exp_sub[8*k +: 8] = pb[k];
  endtask

  task automatic model_select();
    logic [7:0]  hb[3];
    logic [47:0] pair;
    logic [23:0] l, r;
    int          n;
    int          sb[7];
    exp_header = '0;
    exp_sub    = '0;
    if (fifo_q.size() > 0) begin
      exp_type = 3'd1;
      n = (fifo_q.size() > 4) ? 4 : fifo_q.size();
      hb[0] = 8'h02; hb[1] = 8'((1 << n) - 1); hb[2] = 8'h00;
      for (int i = 0; i < n; i++) begin
        pair = fifo_q.pop_front();
        l = pair[47:24];
        r = pair[23:0];
        exp_sub[56*i +: 24]      = l;
        exp_sub[56*i + 24 +: 24] = r;
        exp_sub[56*i + 48 +: 8]  = 8'(($countones(r) % 2) * 128 + ($countones(l) % 2) * 8);
        if (iec == 0) hb[2] = hb[2] | 8'(1 << (4 + i));
        iec = (iec + 1) % 192;
        pairs_done++;
      end
      exp_header = {hb[2], hb[1], hb[0]};
    end else if (m_acr) begin
      exp_type = 3'd2;
      m_acr = 0;
      sb = '{0, CTS / 65536, (CTS / 256) % 256, CTS % 256, NVAL / 65536, (NVAL / 256) % 256, NVAL % 256};
      exp_header = 24'h000001;
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 7; k++) exp_sub[56*i + 8*k +: 8] = 8'(sb[k]);
    end else if (m_avi) begin
      exp_type = 3'd3;
      m_avi = 0;
      model_infoframe(8'h82, 8'h02, 8'h0D, 8'h00, 8'h28, 8'd16);
    end else if (m_aif) begin
      exp_type = 3'd4;
      m_aif = 0;
      model_infoframe(8'h84, 8'h01, 8'h0A, 8'h01, 8'h00, 8'h00);
    end else begin
      exp_type = 3'd0;
    end
  endtask

  task automatic applyStimulus(input bit pe, input bit vfe, input bit av,
                               input logic [23:0] l, input logic [23:0] r);
    bit do_push;
    @(negedge clk_pixel);
    packet_enable = pe; video_field_end = vfe; audio_valid = av;
    audio_left = l; audio_right = r;
    do_push = av && (fifo_q.size() < DEPTH);
    if (pe) model_select();
    if (do_push) fifo_q.push_back({l, r});
    if (vfe) begin
      m_acr = ACR_ON; m_avi = 1; m_aif = 1;
    end
    @(posedge clk_pixel);
    #1;
    packet_enable = 0; video_field_end = 0; audio_valid = 0;
    if (packet_type == 3'd3) saw_avi = 1;
    checkAll("cyc");
  endtask

  task automatic drain();
    int guard = 0;
    while ((fifo_q.size() > 0 || m_acr || m_avi || m_aif) && guard < 50) begin
      applyStimulus(1, 0, 0, 24'h0, 24'h0);
      guard++;
    end
    checkOutput("drain_done", 224'(fifo_q.size() == 0 && !m_acr && !m_avi && !m_aif), 224'(1));
  endtask

  initial begin
    int cyc;
    packet_enable = 0; video_field_end = 0; audio_valid = 0;
    audio_left = '0; audio_right = '0;
    pairs_done = 0; saw_avi = 0;
    reset_n = 0;
    model_reset();
    repeat (3) @(posedge clk_pixel);
    #1;
    checkAll("reset");
    @(negedge clk_pixel) reset_n = 1;

    $display("[TB] null packet after reset");
    applyStimulus(1, 0, 0, 24'h0, 24'h0);
    checkOutput("tp_null_hdr", 224'(header), 224'(0));

    $display("[TB] three-pair audio packet");
    applyStimulus(0, 0, 1, 24'h000001, 24'h800000);
    applyStimulus(0, 0, 1, 24'($urandom), 24'($urandom));
    applyStimulus(0, 0, 1, 24'($urandom), 24'($urandom));
    applyStimulus(1, 0, 0, 24'h0, 24'h0);
    checkOutput("tp_audio_hdr", 224'(header), 224'(24'h100702));
    checkOutput("tp_audio_pcuv", 224'(sub[55:48]), 224'(8'h88));
    checkOutput("tp_audio_sub3", 224'(sub[223:168]), 224'(0));

    $display("[TB] per-field packets");
    applyStimulus(0, 1, 0, 24'h0, 24'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 24'h0, 24'h0);
      if (exp_type == 3'd3) checkOutput("tp_avi_pb0", 224'(sub[7:0]), 224'(8'h37));
      if (exp_type == 3'd4) checkOutput("tp_aif_pb0", 224'(sub[7:0]), 224'(8'h70));
    end
    checkOutput("tp_field_null", 224'(packet_type), 224'(0));

    $display("[TB] FIFO full");
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(0, 0, 1, 24'($urandom), 24'($urandom));
    checkOutput("tp_full_ready", 224'(audio_ready), 224'(0));
    applyStimulus(1, 0, 0, 24'h0, 24'h0);
    checkOutput("tp_pop4_ready", 224'(audio_ready), 224'(1));
    checkOutput("tp_pop4_present", 224'(header[15:8]), 224'(8'h0F));
    drain();

    $display("[TB] random streaming");
    cyc = 0;
    while (pairs_done < 420 && cyc < 8000) begin
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0,
                    $urandom_range(0, 3) != 0, 24'($urandom), 24'($urandom));
      cyc++;
    end
    checkOutput("stream_pairs", 224'(pairs_done >= 420), 224'(1));
    drain();

    $display("[TB] field end on AVI selection");
    applyStimulus(0, 1, 0, 24'h0, 24'h0);
    cyc = 0;
    while (m_acr && cyc < 4) begin
      applyStimulus(1, 0, 0, 24'h0, 24'h0);
      cyc++;
    end
    applyStimulus(1, 1, 0, 24'h0, 24'h0);
    checkOutput("tp_collide_avi", 224'(packet_type), 224'(3));
    saw_avi = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 24'h0, 24'h0);
    checkOutput("tp_avi_resent", 224'(saw_avi), 224'(1));

    $display("[TB] reset mid-slot");
    applyStimulus(0, 0, 1, 24'h123456, 24'h654321);
    applyStimulus(1, 0, 0, 24'h0, 24'h0);
    @(posedge clk_pixel);
    #2;
    reset_n = 0;
    #1;
    model_reset();
    checkAll("midreset");
    @(negedge clk_pixel);
    packet_enable = 1;
    @(posedge clk_pixel);
    #1;
    packet_enable = 0;
    checkAll("reset_pe_ignored");
    @(negedge clk_pixel) reset_n = 1;
    applyStimulus(1, 0, 0, 24'h0, 24'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
